// File: rtl/bus_target.sv
// Bus target for the 8-bit mreq/iorq bus: byte RAM, console TX FIFO, and
// programmable wait-state insertion through buswait_n.
module bus_target #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned MEM_ADDR_BITS = 8,
  parameter int unsigned WAIT_STATES   = 1,
  parameter logic [7:0]  IO_PORT       = 8'h00,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iorq_n,
  input  logic                  mreq_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_n,
  input  logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  buswait_n,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned MEM_WORDS   = 1 << MEM_ADDR_BITS;
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_BITS    = PTR_W + 1;
  localparam logic [3:0]  WS          = 4'(WAIT_STATES);
  localparam logic [7:0]  STATUS_PORT = 8'(IO_PORT + 8'd1);

  logic [DATA_WIDTH-1:0] r_ram [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [3:0]            r_wcnt;

  logic w_live, w_mreq, w_iorq, w_rd, w_wr;
  logic w_mem_hit, w_dp_hit, w_st_hit, w_decoded;
  logic w_read, w_write, w_access, w_dp_write;
  logic w_fifo_empty, w_fifo_full, w_stall, w_done, w_push, w_pop;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Strobes count only when exactly 0; everything is ignored during reset.
  assign w_live = (reset_n === 1'b1);
  assign w_mreq = w_live && (mreq_n === 1'b0);
  assign w_iorq = w_live && (iorq_n === 1'b0);
  assign w_rd   = (rd_n === 1'b0);
  assign w_wr   = (wr_n === 1'b0);

  assign w_mem_hit = w_mreq && (addr[ADDR_WIDTH-1:MEM_ADDR_BITS] == '0);
  assign w_dp_hit  = w_iorq && !w_mreq && (addr[7:0] == IO_PORT);
  assign w_st_hit  = w_iorq && !w_mreq && (addr[7:0] == STATUS_PORT);
  assign w_decoded = w_mem_hit || w_dp_hit || w_st_hit;

  assign w_read     = w_decoded && w_rd && !w_wr;
  assign w_write    = w_decoded && w_wr && !w_rd;
  assign w_access   = w_read || w_write;
  assign w_dp_write = w_dp_hit && w_write;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A console write is also held while the FIFO is full, so push never overflows.
  assign w_stall   = w_access && ((r_wcnt < WS) || (w_dp_write && w_fifo_full));
  assign buswait_n = !w_stall;
  assign w_done    = w_access && !w_stall;
  assign w_push    = w_done && w_dp_write;
  assign w_pop     = !w_fifo_empty && tx_ready;

  always_comb begin
    w_rdata = '0;
    if (w_mem_hit)
      w_rdata = r_ram[addr[MEM_ADDR_BITS-1:0]];
    else if (w_st_hit)
      w_rdata = DATA_WIDTH'({w_fifo_empty, !w_fifo_full});
  end

  assign data     = w_read ? w_rdata : {DATA_WIDTH{1'bz}};
  assign tx_valid = !w_fifo_empty;
  assign tx_data  = w_fifo_empty ? '0 : r_fifo[r_rd_ptr[PTR_W-1:0]];

  // Wait counter: climbs while stalled, clears once an access completes or ends.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_wcnt <= '0;
    else if (w_stall) begin
      if (r_wcnt < WS)
        r_wcnt <= r_wcnt + 4'd1;
    end else
      r_wcnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_WORDS; i++)
        r_ram[i] <= '0;
    end else if (w_done && w_mem_hit && w_write)
      r_ram[addr[MEM_ADDR_BITS-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr[PTR_W-1:0]] <= data;
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
    end
  end

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: one instance with two wait states, one with none.
module tb_bus_target;

  localparam logic [7:0] UNDRV = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sel;
  logic        mreq_n, iorq_n, rd_n, wr_n;
  logic [15:0] addr;
  logic        drv_en;
  logic [7:0]  drv;
  logic        a_tx_ready, b_tx_ready;

  wire a_mreq_n = sel ? 1'b1 : mreq_n;
  wire a_iorq_n = sel ? 1'b1 : iorq_n;
  wire a_rd_n   = sel ? 1'b1 : rd_n;
  wire a_wr_n   = sel ? 1'b1 : wr_n;
  wire b_mreq_n = sel ? mreq_n : 1'b1;
  wire b_iorq_n = sel ? iorq_n : 1'b1;
  wire b_rd_n   = sel ? rd_n : 1'b1;
  wire b_wr_n   = sel ? wr_n : 1'b1;

  wire [7:0] a_data, b_data;
  pullup (a_data);
  pullup (b_data);
  assign a_data = (drv_en && !sel) ? drv : 8'bz;
  assign b_data = (drv_en && sel) ? drv : 8'bz;

  wire       a_bw, b_bw, a_tx_valid, b_tx_valid;
  wire [7:0] a_tx_data, b_tx_data;
  wire [7:0] rdat = sel ? b_data : a_data;
  wire       bw   = sel ? b_bw : a_bw;

  bus_target #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_ADDR_BITS(8), .WAIT_STATES(2),
               .IO_PORT(8'h00), .FIFO_DEPTH(4)) u_ws2 (
    .clk(clk), .reset_n(reset_n), .iorq_n(a_iorq_n), .mreq_n(a_mreq_n), .addr(addr),
    .rd_n(a_rd_n), .wr_n(a_wr_n), .data(a_data), .buswait_n(a_bw),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready));

  bus_target #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_ADDR_BITS(8), .WAIT_STATES(0),
               .IO_PORT(8'h00), .FIFO_DEPTH(4)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .iorq_n(b_iorq_n), .mreq_n(b_mreq_n), .addr(addr),
    .rd_n(b_rd_n), .wr_n(b_wr_n), .data(b_data), .buswait_n(b_bw),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bytes accepted from the zero-wait instance's TX stream.
  logic [7:0] q_rx[$];
  always @(posedge clk)
    if (reset_n && b_tx_valid === 1'b1 && b_tx_ready)
      q_rx.push_back(b_tx_data);

  task automatic idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
  endtask

  // One complete access; returns sampled read data and number of stalled cycles.
  task automatic xact(input logic s, input logic io, input logic rd, input logic [15:0] a,
                      input logic [7:0] wd, output logic [7:0] got, output int waits);
    @(posedge clk); #1;
    sel = s; addr = a; mreq_n = io; iorq_n = !io; rd_n = !rd; wr_n = rd;
    drv = wd; drv_en = !rd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bw === 1'b1) break;
      waits++;
      if (waits > 20) break;
    end
    got = rdat;
    @(posedge clk); #1;
    idle();
  endtask

  typedef struct {
    logic        s;
    logic        io;
    logic        rd;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_d;
    int          exp_w;
  } vec_t;

  vec_t       tbl[17];
  logic [7:0] got;
  int         waits;
  string      msg;
  logic [7:0] bp[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sel = 1'b0; addr = '0; drv = '0;
    a_tx_ready = 1'b0; b_tx_ready = 1'b0;
    idle();

    // Reset with random strobes on the bus.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sel = 1'($urandom); mreq_n = 1'($urandom); iorq_n = 1'($urandom);
      rd_n = 1'($urandom); wr_n = 1'($urandom); addr = 16'($urandom);
      @(negedge clk);
      chk("rst_a_bw", 32'(a_bw), 32'd1);
      chk("rst_b_bw", 32'(b_bw), 32'd1);
      chk("rst_a_data", 32'(a_data), 32'(UNDRV));
      chk("rst_b_data", 32'(b_data), 32'(UNDRV));
      chk("rst_a_txv", 32'(a_tx_valid), 32'd0);
      chk("rst_b_txv", 32'(b_tx_valid), 32'd0);
      chk("rst_b_txd", 32'(b_tx_data), 32'd0);
    end
    @(posedge clk); #1;
    idle(); sel = 1'b0; reset_n = 1'b1;

    //             s   io  rd  addr      wd     exp_d  exp_w
    tbl[0]  = '{1'b0,1'b0,1'b1,16'h0000,8'h00,8'h00,2};
    tbl[1]  = '{1'b0,1'b0,1'b0,16'h0001,8'h99,8'h00,2};
    tbl[2]  = '{1'b0,1'b0,1'b1,16'h0001,8'h00,8'h99,2};
    tbl[3]  = '{1'b0,1'b0,1'b1,16'h0000,8'h00,8'h00,2};
    tbl[4]  = '{1'b0,1'b0,1'b1,16'h8000,8'h00,UNDRV,0};
    tbl[5]  = '{1'b0,1'b1,1'b1,16'h0001,8'h00,8'h03,2};
    tbl[6]  = '{1'b0,1'b1,1'b1,16'h0000,8'h00,8'h00,2};
    tbl[7]  = '{1'b0,1'b0,1'b0,16'h00FF,8'h5A,8'h00,2};
    tbl[8]  = '{1'b0,1'b0,1'b1,16'h00FF,8'h00,8'h5A,2};
    tbl[9]  = '{1'b0,1'b1,1'b1,16'h0005,8'h00,UNDRV,0};
    tbl[10] = '{1'b0,1'b0,1'b1,16'h0100,8'h00,UNDRV,0};
    tbl[11] = '{1'b0,1'b1,1'b0,16'h0001,8'h77,8'h00,2};
    tbl[12] = '{1'b0,1'b1,1'b1,16'h0001,8'h00,8'h03,2};
    tbl[13] = '{1'b0,1'b1,1'b0,16'h0000,8'h41,8'h00,2};
    tbl[14] = '{1'b0,1'b1,1'b1,16'h0001,8'h00,8'h01,2};
    tbl[15] = '{1'b1,1'b0,1'b0,16'h0010,8'hC3,8'h00,0};
    tbl[16] = '{1'b1,1'b0,1'b1,16'h0010,8'h00,8'hC3,0};

    for (int i = 0; i < 17; i++) begin
      xact(tbl[i].s, tbl[i].io, tbl[i].rd, tbl[i].a, tbl[i].wd, got, waits);
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(tbl[i].exp_w));
      if (tbl[i].rd)
        chk($sformatf("vec%0d_data", i), 32'(got), 32'(tbl[i].exp_d));
    end

    // Console byte pushed by vec13 sits in the two-wait instance's FIFO.
    chk("a_txv_after_push", 32'(a_tx_valid), 32'd1);
    chk("a_txd_after_push", 32'(a_tx_data), 32'h41);
    @(posedge clk); #1; a_tx_ready = 1'b1;
    @(posedge clk); #1; a_tx_ready = 1'b0;
    @(negedge clk);
    chk("a_txv_after_pop", 32'(a_tx_valid), 32'd0);
    chk("a_txd_after_pop", 32'(a_tx_data), 32'd0);

    // Console stream with no wait states and a consumer that is always ready.
    msg = "Hello, world!\r\n";
    b_tx_ready = 1'b1;
    q_rx.delete();
    @(posedge clk); #1;
    sel = 1'b1; addr = 16'h0000; iorq_n = 1'b0; wr_n = 1'b0; drv_en = 1'b1;
    for (int i = 0; i < msg.len(); i++) begin
      drv = msg[i];
      @(negedge clk);
      chk($sformatf("console_nostall%0d", i), 32'(bw), 32'd1);
      @(posedge clk); #1;
    end
    idle();
    repeat (5) @(posedge clk);
    chk("console_count", 32'(q_rx.size()), 32'(msg.len()));
    for (int i = 0; i < msg.len() && i < q_rx.size(); i++)
      chk($sformatf("console_byte%0d", i), 32'(q_rx[i]), 32'(msg[i]));

    // Backpressure: consumer stalled, four writes fill the FIFO.
    b_tx_ready = 1'b0;
    @(posedge clk); #1;
    q_rx.delete();
    bp[0] = "H"; bp[1] = "e"; bp[2] = "l"; bp[3] = "l"; bp[4] = "o"; bp[5] = "!";
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b1, 1'b0, 16'h0000, bp[i], got, waits);
      chk($sformatf("bp_fill%0d_waits", i), 32'(waits), 32'd0);
    end
    @(posedge clk); #1;
    sel = 1'b1; addr = 16'h0000; iorq_n = 1'b0; wr_n = 1'b0; drv = bp[4]; drv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d", i), 32'(bw), 32'd0);
    end
    @(posedge clk); #1; b_tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_ready_path", 32'(bw), 32'd0);
    @(posedge clk); #1; b_tx_ready = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bw === 1'b1) break;
      waits++;
      if (waits > 4) break;
    end
    chk("bp_release_waits", 32'(waits), 32'd0);
    @(posedge clk); #1;
    idle();
    chk("bp_popped_count", 32'(q_rx.size()), 32'd1);
    if (q_rx.size() > 0)
      chk("bp_popped_byte", 32'(q_rx[0]), 32'(bp[0]));
    chk("bp_head_byte", 32'(b_tx_data), 32'(bp[1]));
    chk("bp_head_valid", 32'(b_tx_valid), 32'd1);

    // Sixth write stalls on the refilled FIFO, then reset lands mid-stall.
    @(posedge clk); #1;
    sel = 1'b1; addr = 16'h0000; iorq_n = 1'b0; wr_n = 1'b0; drv = bp[5]; drv_en = 1'b1;
    @(negedge clk);
    chk("bp_sixth_stall", 32'(bw), 32'd0);
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_bw_comb", 32'(bw), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_bw", 32'(bw), 32'd1);
    chk("midrst_txv", 32'(b_tx_valid), 32'd0);
    chk("midrst_txd", 32'(b_tx_data), 32'd0);
    @(posedge clk); #1; idle();
    @(posedge clk); #1; reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_txv%0d", i), 32'(b_tx_valid), 32'd0);
    end
    chk("postrst_rx_count", 32'(q_rx.size()), 32'd1);

    // RAM contents are cleared by reset.
    xact(1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, got, waits);
    chk("postrst_b_ram", 32'(got), 32'd0);
    xact(1'b0, 1'b0, 1'b1, 16'h0001, 8'h00, got, waits);
    chk("postrst_a_ram", 32'(got), 32'd0);
    chk("postrst_a_waits", 32'(waits), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
